pll_lock_monitor: RTL and testbench

PLL_LOCK_MONITOR -- requirements
Module: pll_lock_monitor

---
 rtl/pll_mon_pkg.sv | 31 +++
 rtl/sync_2ff.sv | 32 +++
 rtl/pll_lock_monitor.sv | 129 ++++++++++++
 tb/tb_pll_lock_monitor.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_mon_pkg.sv
//------------------------------------------------------------------------------
// Module : pll_mon_pkg
// Brief  : State encoding and default timing constants for pll_lock_monitor.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package pll_mon_pkg;

  localparam int c_pll_rst_cycles      = 16;
  localparam int c_lock_timeout_cycles = 50000;
  localparam int c_lock_stable_cycles  = 1024;
  localparam int c_max_retries         = 3;

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABILIZE = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } pll_state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
//------------------------------------------------------------------------------
// Module : sync_2ff
// Brief  : 1-bit two-flop synchronizer with asynchronous active-low reset.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule

`default_nettype wire

// File: rtl/pll_lock_monitor.sv
//------------------------------------------------------------------------------
// Module : pll_lock_monitor
// Brief  : PLL reset sequencer / lock supervisor with retry and fault handling.
//          Define PLL_MON_LOSS_CNT_EN to build the lock-loss event counter.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module pll_lock_monitor
  import pll_mon_pkg::*;
#(
  parameter int PLL_RST_CYCLES      = c_pll_rst_cycles,
  parameter int LOCK_TIMEOUT_CYCLES = c_lock_timeout_cycles,
  parameter int LOCK_STABLE_CYCLES  = c_lock_stable_cycles,
  parameter int MAX_RETRIES         = c_max_retries
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       locked,
  input  logic       retry_req,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       ready,
  output logic       fault,
  output logic [7:0] lock_loss_cnt,
  output logic [2:0] state
);

  localparam int c_cnt_w   = $clog2(max3(PLL_RST_CYCLES, LOCK_TIMEOUT_CYCLES,
                                         LOCK_STABLE_CYCLES)) + 1;
  localparam int c_retry_w = $clog2(MAX_RETRIES + 1) + 1;

  logic                 w_locked_s;
  pll_state_t           r_state;
  pll_state_t           w_next;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [c_retry_w-1:0] r_retry;
  logic [c_retry_w-1:0] w_retry_inc;
  logic                 w_timeout;
  logic                 r_pll_rst;
  logic                 r_sys_rst_n;
  logic                 r_ready;
  logic                 r_fault;

  sync_2ff u_lock_sync (
    .clk   (refclk),
    .rst_n (rst_n),
    .d     (locked),
    .q     (w_locked_s)
  );

  assign w_retry_inc = r_retry + c_retry_w'(1);
  assign w_timeout   = (r_cnt == c_cnt_w'(LOCK_TIMEOUT_CYCLES - 1));

  // Lock drop is tested before stabilization completion so the drop wins a tie.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_PLL_RST:
        if (r_cnt == c_cnt_w'(PLL_RST_CYCLES - 1)) w_next = ST_WAIT_LOCK;
      ST_WAIT_LOCK:
        if (w_locked_s)     w_next = ST_STABILIZE;
        else if (w_timeout) w_next = (w_retry_inc == c_retry_w'(MAX_RETRIES))
                                     ? ST_FAULT : ST_PLL_RST;
      ST_STABILIZE:
        if (!w_locked_s) w_next = ST_WAIT_LOCK;
        else if (r_cnt == c_cnt_w'(LOCK_STABLE_CYCLES - 1)) w_next = ST_RUN;
      ST_RUN:
        if (!w_locked_s) w_next = ST_PLL_RST;
      ST_FAULT:
        if (retry_req) w_next = ST_PLL_RST;
      default:
        w_next = ST_PLL_RST;
    endcase
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_PLL_RST;
      r_cnt       <= '0;
      r_retry     <= '0;
      r_pll_rst   <= 1'b1;
      r_sys_rst_n <= 1'b0;
      r_ready     <= 1'b0;
      r_fault     <= 1'b0;
    end else begin
      r_state <= w_next;

      // Every state change restarts the cycle count; otherwise it holds at max.
      if (w_next != r_state)  r_cnt <= '0;
      else if (r_cnt != '1)   r_cnt <= r_cnt + c_cnt_w'(1);

      if (r_state == ST_WAIT_LOCK && !w_locked_s && w_timeout)
        r_retry <= w_retry_inc;
      else if ((w_next == ST_RUN && r_state != ST_RUN) ||
               (r_state == ST_FAULT && retry_req))
        r_retry <= '0;

      r_pll_rst   <= (w_next == ST_PLL_RST) || (w_next == ST_FAULT);
      r_sys_rst_n <= (w_next == ST_RUN);
      r_ready     <= (w_next == ST_RUN);
      r_fault     <= (w_next == ST_FAULT);
    end
  end

`ifdef PLL_MON_LOSS_CNT_EN
  logic [7:0] r_loss_cnt;

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n)
      r_loss_cnt <= 8'h00;
    else if (r_state == ST_RUN && w_next == ST_PLL_RST && r_loss_cnt != 8'hFF)
      r_loss_cnt <= r_loss_cnt + 8'h01;
  end

  assign lock_loss_cnt = r_loss_cnt;
`else
  assign lock_loss_cnt = 8'h00;
`endif

  assign pll_rst   = r_pll_rst;
  assign sys_rst_n = r_sys_rst_n;
  assign ready     = r_ready;
  assign fault     = r_fault;
  assign state     = r_state;

endmodule

`default_nettype wire

// File: tb/tb_pll_lock_monitor.sv
//------------------------------------------------------------------------------
// Module : tb_pll_lock_monitor
// Brief  : Self-checking bench for pll_lock_monitor (honours PLL_MON_LOSS_CNT_EN).
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_pll_lock_monitor;
  import pll_mon_pkg::*;

  localparam int c_prc = 4;
  localparam int c_to  = 100;
  localparam int c_st  = 8;
  localparam int c_mr  = 3;
`ifdef PLL_MON_LOSS_CNT_EN
  localparam bit c_loss_en = 1'b1;
`else
  localparam bit c_loss_en = 1'b0;
`endif

  logic       refclk = 1'b0;
  logic       rst_n;
  logic       locked;
  logic       retry_req;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       ready;
  logic       fault;
  logic [7:0] lock_loss_cnt;
  logic [2:0] state;

  int n_cmp = 0;
  int n_mis = 0;

  pll_lock_monitor #(
    .PLL_RST_CYCLES      (c_prc),
    .LOCK_TIMEOUT_CYCLES (c_to),
    .LOCK_STABLE_CYCLES  (c_st),
    .MAX_RETRIES         (c_mr)
  ) dut (
    .refclk        (refclk),
    .rst_n         (rst_n),
    .locked        (locked),
    .retry_req     (retry_req),
    .pll_rst       (pll_rst),
    .sys_rst_n     (sys_rst_n),
    .ready         (ready),
    .fault         (fault),
    .lock_loss_cnt (lock_loss_cnt),
    .state         (state)
  );

  always #5 refclk = ~refclk;

  // Reference model: phase index, elapsed cycles in phase, retry and loss tallies,
  // and a two-deep history of the raw lock input standing in for the synchronizer.
  int m_ph, m_t, m_retry, m_loss;
  bit m_h1, m_h2;

  function automatic void m_reset();
    m_ph = 0; m_t = 0; m_retry = 0; m_loss = 0; m_h1 = 0; m_h2 = 0;
  endfunction

  function automatic void m_step(input bit lk, input bit rq);
    bit ls;
    ls = m_h2; m_h2 = m_h1; m_h1 = lk;
    case (m_ph)
      0: begin m_t++; if (m_t == c_prc) begin m_ph = 1; m_t = 0; end end
      1: if (ls) begin m_ph = 2; m_t = 0; end
         else begin
           m_t++;
           if (m_t == c_to) begin
             m_retry++; m_t = 0;
             m_ph = (m_retry == c_mr) ? 4 : 0;
           end
         end
      2: if (!ls) begin m_ph = 1; m_t = 0; end
         else begin m_t++; if (m_t == c_st) begin m_ph = 3; m_retry = 0; end end
      3: if (!ls) begin
           m_ph = 0; m_t = 0;
           if (c_loss_en && m_loss < 255) m_loss++;
         end
      default: if (rq) begin m_ph = 0; m_t = 0; m_retry = 0; end
    endcase
  endfunction

  function automatic logic [2:0] ph2st(input int ph);
    case (ph)
      0: return ST_PLL_RST;
      1: return ST_WAIT_LOCK;
      2: return ST_STABILIZE;
      3: return ST_RUN;
      default: return ST_FAULT;
    endcase
  endfunction

  function automatic logic [14:0] m_vec();
    return {ph2st(m_ph), (m_ph == 0 || m_ph == 4), (m_ph == 3), (m_ph == 3),
            (m_ph == 4), 8'(m_loss)};
  endfunction

  function automatic logic [14:0] dut_vec();
    return {state, pll_rst, sys_rst_n, ready, fault, lock_loss_cnt};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge refclk);
    if (!rst_n) m_reset();
    else        m_step(locked, retry_req);
    #1;
    check("model", 32'(dut_vec()), 32'(m_vec()));
  endtask

  typedef struct {
    bit         lk;
    bit         rq;
    int         n;
    logic [2:0] st;
    bit         pr, sr, rd, ft;
    bit         loss;
  } vec_t;

  vec_t vt[8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n_wait, n_prst, k;
    bit seen_run, seen_bad, was_wait;

    vt[0] = '{1'b1, 1'b0, 3, ST_PLL_RST,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[1] = '{1'b1, 1'b0, 1, ST_WAIT_LOCK, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[2] = '{1'b1, 1'b0, 1, ST_STABILIZE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[3] = '{1'b1, 1'b0, 7, ST_STABILIZE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[4] = '{1'b1, 1'b1, 1, ST_RUN,       1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vt[5] = '{1'b0, 1'b0, 1, ST_RUN,       1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vt[6] = '{1'b1, 1'b1, 1, ST_RUN,       1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vt[7] = '{1'b1, 1'b0, 1, ST_PLL_RST,   1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

    rst_n = 1'b0; locked = 1'b1; retry_req = 1'b0;
    m_reset();
    tick(); tick();
    check("reset_values", 32'(dut_vec()), 32'({ST_PLL_RST, 4'b1000, 8'h00}));
    rst_n = 1'b1;

    // Bring-up with lock present, then a one-cycle lock glitch in RUN.
    for (int i = 0; i < 8; i++) begin
      locked = vt[i].lk; retry_req = vt[i].rq;
      repeat (vt[i].n) tick();
      check($sformatf("vec%0d", i), 32'(dut_vec()),
            32'({vt[i].st, vt[i].pr, vt[i].sr, vt[i].rd, vt[i].ft,
                 (vt[i].loss && c_loss_en) ? 8'd1 : 8'd0}));
    end
    retry_req = 1'b0;

    // Lock never arrives: three timeouts then FAULT.
    locked = 1'b0; n_wait = 0; n_prst = 0;
    repeat (400) begin
      tick();
      if (state == ST_WAIT_LOCK) n_wait++;
      if (state == ST_PLL_RST)   n_prst++;
    end
    check("timeout_wait_cycles", n_wait, 3 * c_to);
    check("timeout_prst_cycles", n_prst, 3 + 2 * c_prc);
    check("fault_state", 32'(state), 32'(ST_FAULT));
    check("fault_flag", fault, 1);
    check("fault_pll_rst", pll_rst, 1);
    check("fault_sys_rst_n", sys_rst_n, 0);
    retry_req = 1'b1; tick(); retry_req = 1'b0;
    check("retry_exit", 32'({state, pll_rst, fault}), 32'({ST_PLL_RST, 2'b10}));

    // Lock chatter: 7 high / 1 low never stabilizes and never times out.
    seen_run = 0; seen_bad = 0; was_wait = 0;
    for (int p = 0; p < 20; p++) begin
      for (int c = 0; c < 8; c++) begin
        locked = (c != 7);
        tick();
        if (ready) seen_run = 1;
        if (state == ST_WAIT_LOCK) was_wait = 1;
        if (state == ST_FAULT || (was_wait && state == ST_PLL_RST)) seen_bad = 1;
      end
    end
    check("chatter_no_run", seen_run, 0);
    check("chatter_no_retry", seen_bad, 0);

    // Randomized lock behaviour and retry requests against the model.
    repeat (60) begin
      int len;
      locked = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       len = $urandom_range(1, 4);
        1:       len = $urandom_range(5, 20);
        2:       len = $urandom_range(20, 60);
        default: len = 130;
      endcase
      repeat (len) begin
        retry_req = ($urandom_range(0, 15) == 0);
        tick();
      end
    end
    retry_req = 1'b0;

    // 300 lock-loss events: counter saturates at 255.
    retry_req = 1'b1; tick(); retry_req = 1'b0;
    locked = 1'b1;
    for (int ev = 0; ev < 300; ev++) begin
      k = 0;
      while (!ready && k < 60) begin tick(); k++; end
      check("sat_reach_run", ready, 1);
      if (!ready) break;
      locked = 1'b0; tick(); locked = 1'b1;
      k = 0;
      while (ready && k < 10) begin tick(); k++; end
    end
    check("loss_saturate", lock_loss_cnt, c_loss_en ? 255 : 0);

    // Asynchronous reset in the middle of STABILIZE.
    locked = 1'b0; repeat (3) tick();
    locked = 1'b1; k = 0;
    while (state != ST_STABILIZE && k < 60) begin tick(); k++; end
    check("reach_stabilize", 32'(state), 32'(ST_STABILIZE));
    tick(); tick();
    #3 rst_n = 1'b0;
    #1 check("async_reset", 32'(dut_vec()), 32'({ST_PLL_RST, 4'b1000, 8'h00}));
    m_reset();
    tick(); tick();
    rst_n = 1'b1;
    k = 0;
    while (pll_rst && k < 20) begin tick(); k++; end
    check("post_reset_pulse", k, c_prc);
    repeat (20) tick();
    check("post_reset_run", ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

`default_nettype wire
